multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Moore control FSM that sequences the 64-bit multicycle RISC-V datapath (PC, IR, reg bank, A/B, ALU, ALUOut, MDR, data mem).
//  Decodes IR opcode/funct fields; drives every mux select, write enable and ALU op.
//  Supported: R add/sub/and/or, addi, ld, sd, beq, bne. One instruction in flight.
// PARAMETERS
//  MEM_LAT  1  read latency (cycles) of instruction and data memories; legal 1..3
// PORTS
//  clock      in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high
//  opcode     in   7  IR[6:0]
//  funct3     in   3  IR[14:12]
//  funct7     in   7  IR[31:25]
//  alu_zero   in   1  ALU result == 0 (combinational, current cycle)
//  pc_write   out  1  PC <= ALU S
//  ir_load    out  1  IR <= instruction memory data
//  alu_sel    out  3  ALU operation (ctrl_pkg::alu_op_t)
//  mux_a_sel  out  3  ALU A: 0=PC, 1=RegA
//  mux_b_sel  out  3  ALU B: 0=RegB, 1=const 4, 2=imm, 3=imm<<1
//  dmem_wr    out  1  data memory write, addr=ALUOut, data=RegB
//  rf_wr      out  1  reg bank write at rd
//  rf_src_sel out  3  reg write data: 0=ALUOut, 1=MDR
//  busy       out  1  high in every state except FETCH
//  illegal    out  1  sticky; see CONFIGURATION
// BEHAVIOUR
//  Moore outputs decoded from state only; default all enables 0, selects 0, alu_sel=ADD.
//  Reset: state=FETCH, wait counter=0, illegal=0; all outputs at defaults during reset.
//  Reset mid-instruction aborts at once; no write enable may pulse after reset asserts.
//  FETCH: hold MEM_LAT cycles (counter), last cycle ir_load=1 -> DECODE.
//  DECODE: A/B latch; branch opcodes -> BR_CMP; others pc_write=1, A=PC,B=4,ADD -> dispatch.
//   0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> MEM_ADDR; else -> ILLEGAL handling.
//  EXEC_R: A=RegA,B=RegB; funct7[5]=1&funct3=000 -> SUB; 000 ADD; 111 AND; 110 OR -> WB_ALU.
//  EXEC_I: A=RegA,B=imm,ADD -> WB_ALU.  WB_ALU: rf_wr=1, rf_src=0 -> FETCH.
//  MEM_ADDR: A=RegA,B=imm,ADD -> ld: MEM_RD ; sd: MEM_WR.
//  MEM_RD: hold MEM_LAT cycles -> WB_MEM (rf_wr=1, rf_src=1) -> FETCH.
//  MEM_WR: dmem_wr=1 exactly one cycle -> FETCH.
//  BR_CMP: A=RegA,B=RegB,SUB; taken = beq?alu_zero:!alu_zero -> BR_TAKE else BR_NEXT.
//  BR_TAKE: A=PC,B=imm<<1,ADD,pc_write=1 -> FETCH.  BR_NEXT: A=PC,B=4,pc_write=1 -> FETCH.
//  Latency (MEM_LAT=1): R/I 4, sd 4, ld 5, branch 4 cycles.
//  Exactly one pc_write pulse per instruction; ALU arithmetic wraps mod 2^64 (no trap).
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: unknown opcode/funct -> HALT; illegal=1, busy=1, all enables 0 until reset.
//  Not defined: unknown encoding executes as NOP (DECODE pc_write only, -> FETCH); illegal tied 0.
// STRUCTURE
//  ctrl_pkg: state_t enum, alu_op_t (PASS=000,ADD=001,SUB=010,AND=011,OR=100), opcode localparams,
//   mux select localparams (MUXA_*, MUXB_*, RFSRC_*).
//  Sub-module mem_wait_cnt: loadable down-counter, done pulse after MEM_LAT cycles (FETCH, MEM_RD).
//  State register + next-state always_comb + output always_comb in this module.
// TESTING
//  Reset in BR_TAKE mid-cycle -> state FETCH, pc_write/rf_wr/dmem_wr 0 same cycle, illegal 0.
//  add x3,x1,x2 (0x002081B3) -> ir_load cyc1, pc_write cyc2 (PC,4), EXEC_R SUB=0 ADD, rf_wr cyc4 only.
//  sub (funct7=0100000) -> alu_sel=SUB in EXEC_R; or (funct3=110) -> OR.
//  ld with MEM_LAT=3 -> MEM_RD held 3 cycles, rf_wr with rf_src=1 one cycle, total 9 cycles.
//  beq alu_zero=1 -> BR_TAKE mux_b=3 pc_write; alu_zero=0 -> BR_NEXT mux_b=1; bne inverted.
//  opcode 7'b1111111: with ILLEGAL_TRAP_EN illegal=1 held 100 cycles, no enables; without -> next FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multicycle RISC-V control FSM.
// State encoding, ALU operation codes, opcode/funct constants, datapath
// mux select codes and a small instruction classifier used by the FSM.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_MEM   = 4'd8,
        BR_CMP   = 4'd9,
        BR_TAKE  = 4'd10,
        BR_NEXT  = 4'd11,
        HALT     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100
    } alu_op_t;

    // Instruction families the FSM knows how to sequence
    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_LD  = 3'd2,
        CL_SD  = 3'd3,
        CL_BR  = 3'd4,
        CL_BAD = 3'd5
    } instr_class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_DWORD   = 3'b011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [2:0] MUXA_PC      = 3'd0;
    localparam logic [2:0] MUXA_REGA    = 3'd1;
    localparam logic [2:0] MUXB_REGB    = 3'd0;
    localparam logic [2:0] MUXB_FOUR    = 3'd1;
    localparam logic [2:0] MUXB_IMM     = 3'd2;
    localparam logic [2:0] MUXB_IMM_SH1 = 3'd3;
    localparam logic [2:0] RFSRC_ALUOUT = 3'd0;
    localparam logic [2:0] RFSRC_MDR    = 3'd1;

    // Map the IR fields onto a supported instruction family (or CL_BAD)
    function automatic instr_class_t classify(input logic [6:0] opcode,
                                              input logic [2:0] funct3,
                                              input logic [6:0] funct7);
        instr_class_t cls;
        cls = CL_BAD;
        case (opcode)
            OPC_R: begin
                if ((funct7 == F7_BASE) &&
                    ((funct3 == F3_ADD) || (funct3 == F3_OR) || (funct3 == F3_AND))) begin
                    cls = CL_R;
                end else if ((funct7 == F7_ALT) && (funct3 == F3_ADD)) begin
                    cls = CL_R;
                end else begin
                    cls = CL_BAD;
                end
            end
            OPC_IMM:    cls = (funct3 == F3_ADD)   ? CL_I  : CL_BAD;
            OPC_LOAD:   cls = (funct3 == F3_DWORD) ? CL_LD : CL_BAD;
            OPC_STORE:  cls = (funct3 == F3_DWORD) ? CL_SD : CL_BAD;
            OPC_BRANCH: cls = ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) ? CL_BR : CL_BAD;
            default:    cls = CL_BAD;
        endcase
        return cls;
    endfunction

    // ALU operation for a legal R-type instruction
    function automatic alu_op_t r_alu_op(input logic [2:0] funct3,
                                         input logic [6:0] funct7);
        alu_op_t op;
        op = ALU_ADD;
        case (funct3)
            F3_ADD:  op = funct7[5] ? ALU_SUB : ALU_ADD;
            F3_AND:  op = ALU_AND;
            F3_OR:   op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait.sv
// mem_wait_cnt: wait-cycle counter for memory accesses of MEM_LAT cycles.
// While run is high the counter advances each cycle; done is high during
// the last (MEM_LAT-th) cycle. Outside a wait the count returns to zero,
// so every wait state entered starts a fresh MEM_LAT-cycle window.
module mem_wait_cnt #(
    parameter int MEM_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic done
);

    localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

    logic [1:0] cnt_r;

    // Count elapsed wait cycles; clear when idle or on the final cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= 2'd0;
        end else if (run && !done) begin
            cnt_r <= cnt_r + 2'd1;
        end else begin
            cnt_r <= 2'd0;
        end
    end

    assign done = run && (cnt_r == LAST_CNT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore control FSM for the 64-bit multicycle RISC-V
// datapath (add/sub/and/or, addi, ld, sd, beq, bne; one instruction in flight).
// Optional feature macro ILLEGAL_TRAP_EN: when defined, an unknown encoding
// parks the FSM in HALT with illegal=1 until reset; when undefined it is
// executed as a NOP and illegal stays 0.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic       ir_load,
    output logic [2:0] alu_sel,
    output logic [2:0] mux_a_sel,
    output logic [2:0] mux_b_sel,
    output logic       dmem_wr,
    output logic       rf_wr,
    output logic [2:0] rf_src_sel,
    output logic       busy,
    output logic       illegal
);

    state_t       state_r;
    state_t       state_s;
    instr_class_t cls_s;
    logic         wait_run_s;
    logic         wait_done_s;
    logic         br_taken_s;

    assign cls_s      = classify(opcode, funct3, funct7);
    assign wait_run_s = (state_r == FETCH) || (state_r == MEM_RD);
    assign br_taken_s = (funct3 == F3_BEQ) ? alu_zero : !alu_zero;

    mem_wait_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_mem_wait (
        .clock (clock),
        .reset (reset),
        .run   (wait_run_s),
        .done  (wait_done_s)
    );

    // State register; reset aborts any instruction immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_s = state_r;
        case (state_r)
            FETCH:    state_s = wait_done_s ? DECODE : FETCH;
            DECODE: begin
                case (cls_s)
                    CL_R:         state_s = EXEC_R;
                    CL_I:         state_s = EXEC_I;
                    CL_LD, CL_SD: state_s = MEM_ADDR;
                    CL_BR:        state_s = BR_CMP;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_s = HALT;
`else
                    default:      state_s = FETCH;
`endif
                endcase
            end
            EXEC_R:   state_s = WB_ALU;
            EXEC_I:   state_s = WB_ALU;
            WB_ALU:   state_s = FETCH;
            MEM_ADDR: state_s = (cls_s == CL_SD) ? MEM_WR : MEM_RD;
            MEM_RD:   state_s = wait_done_s ? WB_MEM : MEM_RD;
            WB_MEM:   state_s = FETCH;
            MEM_WR:   state_s = FETCH;
            BR_CMP:   state_s = br_taken_s ? BR_TAKE : BR_NEXT;
            BR_TAKE:  state_s = FETCH;
            BR_NEXT:  state_s = FETCH;
`ifdef ILLEGAL_TRAP_EN
            HALT:     state_s = HALT;
`else
            HALT:     state_s = FETCH;
`endif
            default:  state_s = FETCH;
        endcase
    end

    // Output decode from the current state; forced idle while reset is held
    always_comb begin
        pc_write   = 1'b0;
        ir_load    = 1'b0;
        alu_sel    = ALU_ADD;
        mux_a_sel  = MUXA_PC;
        mux_b_sel  = MUXB_REGB;
        dmem_wr    = 1'b0;
        rf_wr      = 1'b0;
        rf_src_sel = RFSRC_ALUOUT;
        busy       = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            busy = (state_r != FETCH);
            case (state_r)
                FETCH: begin
                    ir_load = wait_done_s;
                end
                DECODE: begin
                    // PC+4 is always computed; only non-branches commit it here
                    mux_a_sel = MUXA_PC;
                    mux_b_sel = MUXB_FOUR;
`ifdef ILLEGAL_TRAP_EN
                    pc_write  = (cls_s != CL_BR) && (cls_s != CL_BAD);
`else
                    pc_write  = (cls_s != CL_BR);
`endif
                end
                EXEC_R: begin
                    mux_a_sel = MUXA_REGA;
                    mux_b_sel = MUXB_REGB;
                    alu_sel   = r_alu_op(funct3, funct7);
                end
                EXEC_I, MEM_ADDR: begin
                    mux_a_sel = MUXA_REGA;
                    mux_b_sel = MUXB_IMM;
                end
                WB_ALU: begin
                    rf_wr      = 1'b1;
                    rf_src_sel = RFSRC_ALUOUT;
                end
                MEM_RD: begin
                    busy = 1'b1;
                end
                WB_MEM: begin
                    rf_wr      = 1'b1;
                    rf_src_sel = RFSRC_MDR;
                end
                MEM_WR: begin
                    dmem_wr = 1'b1;
                end
                BR_CMP: begin
                    mux_a_sel = MUXA_REGA;
                    mux_b_sel = MUXB_REGB;
                    alu_sel   = ALU_SUB;
                end
                BR_TAKE: begin
                    mux_a_sel = MUXA_PC;
                    mux_b_sel = MUXB_IMM_SH1;
                    pc_write  = 1'b1;
                end
                BR_NEXT: begin
                    mux_a_sel = MUXA_PC;
                    mux_b_sel = MUXB_FOUR;
                    pc_write  = 1'b1;
                end
                HALT: begin
`ifdef ILLEGAL_TRAP_EN
                    illegal = 1'b1;
`else
                    illegal = 1'b0;
`endif
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
        end else begin
            busy = 1'b0;
        end
    end

endmodule
